// File: rtl/nibble_word_packer.sv
// Packs eight 4-bit nibbles into one 32-bit word (slot k at out_w[4k:4k+3]) with
// valid/ready on both sides. Optional flush of a partial word under `PACKER_FLUSH_EN.
//
// state      | meaning
// FILL       | out_valid=0, assembling nibbles into the buffer
// FILL+HOLD  | out_valid=1, s<7, word waiting while slots 0..6 keep filling
// BLOCKED    | out_valid=1, s==7, out_ready=0: slot-7 nibble refused
module nibble_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_nib,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [0:31] out_w,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef PACKER_FLUSH_EN
    input  logic        flush,
`endif
    output logic [2:0]  s
);

    logic [0:31] asm_buf;
    logic [0:31] asm_buf_nxt;
    logic [0:31] out_w_nxt;
    logic        out_valid_nxt;
    logic [2:0]  s_nxt;
    logic        take_nib;
    logic        complete;
    logic        out_free;
`ifdef PACKER_FLUSH_EN
    logic        flush_take;
    logic [0:31] flush_mask;
`endif

    assign out_free = !out_valid || out_ready;

    always_comb begin
`ifdef PACKER_FLUSH_EN
        // flush owns the cycle: a concurrent nibble is never taken
        in_ready = ((s != 3'd7) || out_free) && !flush;
`else
        in_ready = (s != 3'd7) || out_free;
`endif
    end

    always_comb begin
        take_nib      = in_valid && in_ready;
        complete      = take_nib && (s == 3'd7);
        asm_buf_nxt   = asm_buf;
        out_w_nxt     = out_w;
        out_valid_nxt = out_valid;
        s_nxt         = s;

        if (out_valid && out_ready)
            out_valid_nxt = 1'b0;

        if (take_nib) begin
            asm_buf_nxt[{s, 2'b00} +: 4] = in_nib;
            s_nxt = s + 3'd1;
        end

        if (complete) begin
            out_w_nxt     = {asm_buf[0:27], in_nib};
            out_valid_nxt = 1'b1;
        end

`ifdef PACKER_FLUSH_EN
        flush_take = flush && out_free && (s != 3'd0);
        flush_mask = '0;
        for (int k = 0; k < 8; k++) begin
            if (3'(k) < s)
                flush_mask[4*k +: 4] = 4'hF;
        end
        if (flush_take) begin
            out_w_nxt     = asm_buf & flush_mask;
            out_valid_nxt = 1'b1;
            s_nxt         = 3'd0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_buf   <= '0;
            out_w     <= '0;
            out_valid <= 1'b0;
            s         <= 3'd0;
        end else begin
            asm_buf   <= asm_buf_nxt;
            out_w     <= out_w_nxt;
            out_valid <= out_valid_nxt;
            s         <= s_nxt;
        end
    end

endmodule

// File: tb/tb_nibble_word_packer.sv
// Scoreboard bench for nibble_word_packer: expected words queued at stimulus time,
// popped and compared by a monitor on every output handshake.
module tb_nibble_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_nib;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] out_w;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  s;
`ifdef PACKER_FLUSH_EN
    logic        flush;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stall_cnt = 0;
    logic [31:0] exp_q[$];
    int          pop_cyc[$];

    nibble_word_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_nib    (in_nib),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_w     (out_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PACKER_FLUSH_EN
        .flush     (flush),
`endif
        .s         (s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in_valid && !in_ready) stall_cnt++;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL word_unexpected actual=%h required=none", out_w);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_w !== e) begin
                    failures++;
                    $display("FAIL word actual=%h required=%h", out_w, e);
                end
            end
            pop_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [3:0] n);
        int w = 0;
        in_valid = 1'b1;
        in_nib   = n;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accept nib=%h", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_nib   = 4'h0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_q.push_back(v);
            send(v[31-4*i -: 4]);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_nib = 4'h0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef PACKER_FLUSH_EN
        flush = 1'b0;
`endif
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic word, 1-clk latency, valid for exactly one clk
        send_word(32'h12345678);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        check("one_clk_valid", 32'(out_valid), 32'd0);

        // continuous stream, no in_ready drop, 8 clk spacing
        stall_cnt = 0;
        send_word(32'hABCDEF01);
        send_word(32'h23456789);
        @(posedge clk); #1;
        check("no_stall", 32'(stall_cnt), 32'd0);
        check("spacing", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2]), 32'd8);

        // stalled output, hold fill, blocked at s==7, handover
        out_ready = 1'b0;
        send_word(32'h12345678);
        for (int i = 0; i < 7; i++) send(4'(9 + i));
        check("hold_s", 32'(s), 32'd7);
        check("hold_out_w", out_w, 32'h12345678);
        check("hold_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1; in_nib = 4'h0;
        exp_q.push_back(32'h9ABCDEF0);
        @(negedge clk);
        check("blocked_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("blocked_out_w", out_w, 32'h12345678);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("handover_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("handover_valid", 32'(out_valid), 32'd1);
        check("handover_out_w", out_w, 32'h9ABCDEF0);
        check("handover_s", 32'(s), 32'd0);
        @(posedge clk); #1;

        // partial fill then s check
        send(4'h3); send(4'h4); send(4'h5);
        check("partial_s", 32'(s), 32'd3);

`ifdef PACKER_FLUSH_EN
        @(posedge clk); #1;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        @(posedge clk); #1;
        send(4'h9); send(4'h8); send(4'h7);
        exp_q.push_back(32'h98700000);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_s", 32'(s), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd1);
        check("flush_out_w", out_w, 32'h98700000);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_s0_noop", 32'(out_valid), 32'd0);
`endif

        // async reset mid-stream with a pending word
        out_ready = 1'b0;
        send_word(32'h11112222);
        send(4'h3); send(4'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_w", out_w, 32'h0);
        check("arst_s", 32'(s), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_word(32'hCAFE0001);
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
